// File: rtl/mod_residue_accumulator_if.sv
// Handshake bundle between the residue LUT stages, the accumulator and the
// result consumer.
//   in_valid / in_ready / in_residue : partial residue stream into the accumulator
//   out_valid / out_ready / out_residue / out_err : final residue out of it
// Modports:
//   master : the environment (drives residues, accepts results)
//   slave  : the accumulator
interface mod_residue_accumulator_if #(
    parameter int unsigned RES_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [RES_W-1:0] in_residue;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_residue;
    logic             out_err;

    modport master (
        output in_valid, in_residue, out_ready,
        input  in_ready, out_valid, out_residue, out_err
    );

    modport slave (
        input  in_valid, in_residue, out_ready,
        output in_ready, out_valid, out_residue, out_err
    );
endinterface

// File: rtl/mod_residue_accumulator.sv
// Modular residue accumulator. Accepts NUM_CHUNKS partial residues (one per
// in_valid/in_ready handshake), sums them modulo MODULUS and presents the
// final residue on out_valid/out_ready.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   clear : synchronous abort, discards the partial sum (wins over both handshakes)
//   bus   : slave modport of mod_residue_accumulator_if (residue in, result out)
// Optional build macro MOD_ACC_RANGE_CHECK_EN: adds a sticky flag reported on
// out_err in DONE when any accepted residue was >= MODULUS. Without it
// out_err is tied low; result values are the same in both builds.
module mod_residue_accumulator #(
    parameter int unsigned MODULUS    = 461,
    parameter int unsigned RES_W      = 9,
    parameter int unsigned NUM_CHUNKS = 84,
    parameter int unsigned CNT_W      = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    mod_residue_accumulator_if.slave      bus
);

    localparam logic [RES_W:0]   MOD_EXT  = (RES_W + 1)'(MODULUS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [0:0] {StAccum, StDone} state_e;

    state_e           state_q;
    logic [RES_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic [RES_W:0]   r_ext;
    logic [RES_W:0]   sum;
    logic [RES_W-1:0] acc_next;

    assign accept = bus.in_valid && (state_q == StAccum);

    // Inputs are at most 2^RES_W-1 < 2*MODULUS, so one subtract brings them
    // into range; the sum of two in-range values is at most 2*MODULUS-2, so
    // one more conditional subtract completes the reduction.
    always_comb begin
        r_ext = {1'b0, bus.in_residue};
        if (r_ext >= MOD_EXT) begin
            r_ext = r_ext - MOD_EXT;
        end
        sum      = {1'b0, acc_q} + r_ext;
        acc_next = (sum >= MOD_EXT) ? RES_W'(sum - MOD_EXT) : RES_W'(sum);
    end

`ifdef MOD_ACC_RANGE_CHECK_EN
    logic err_q;
    logic in_oor;

    assign in_oor = ({1'b0, bus.in_residue} >= MOD_EXT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MOD_ACC_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (clear) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MOD_ACC_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        acc_q <= acc_next;
`ifdef MOD_ACC_RANGE_CHECK_EN
                        if (in_oor) begin
                            err_q <= 1'b1;
                        end
`endif
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    // Result held until the consumer takes it.
                    if (bus.out_ready) begin
                        acc_q   <= '0;
                        state_q <= StAccum;
`ifdef MOD_ACC_RANGE_CHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

    // All outputs decode directly from registers.
    assign bus.in_ready    = (state_q == StAccum);
    assign bus.out_valid   = (state_q == StDone);
    assign bus.out_residue = acc_q;
`ifdef MOD_ACC_RANGE_CHECK_EN
    assign bus.out_err     = err_q && (state_q == StDone);
`else
    assign bus.out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mod_residue_accumulator.sv
module tb_mod_residue_accumulator;

    localparam int unsigned MODULUS    = 461;
    localparam int unsigned RES_W      = 9;
    localparam int unsigned NUM_CHUNKS = 84;

`ifdef MOD_ACC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct {
        int unsigned res;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;

    int checks = 0;
    int failures = 0;

    int unsigned model_acc = 0;
    bit          model_err = 1'b0;
    exp_t        sb_q[$];

    mod_residue_accumulator_if #(.RES_W(RES_W)) bus ();

    mod_residue_accumulator #(
        .MODULUS    (MODULUS),
        .RES_W      (RES_W),
        .NUM_CHUNKS (NUM_CHUNKS),
        .CNT_W      (7)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One beat: offered just after a rising edge, accepted on the next one.
    task automatic send(input int unsigned v);
        int unsigned r;
        bus.in_valid   = 1'b1;
        bus.in_residue = RES_W'(v);
        @(negedge clk);
        chk("in_ready_accum", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        r = (v >= MODULUS) ? v - MODULUS : v;
        model_acc = (model_acc + r) % MODULUS;
        if (v >= MODULUS && RANGE_EN) model_err = 1'b1;
    endtask

    task automatic send_n(input int n, input int unsigned v);
        for (int i = 0; i < n; i++) send(v);
    endtask

    // Operand complete: record the expected result and restart the model.
    task automatic end_op();
        exp_t e;
        bus.in_valid = 1'b0;
        e.res = model_acc;
        e.err = model_err;
        sb_q.push_back(e);
        model_acc = 0;
        model_err = 1'b0;
    endtask

    // out_valid must already be up in the cycle after the last accept.
    task automatic collect();
        exp_t e;
        @(negedge clk);
        chk("out_valid_latency", 32'(bus.out_valid), 1);
        chk("in_ready_done", 32'(bus.in_ready), 0);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk("out_residue", 32'(bus.out_residue), e.res);
            chk("out_err", 32'(bus.out_err), 32'(e.err));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid_after_hs", 32'(bus.out_valid), 0);
        chk("in_ready_after_hs", 32'(bus.in_ready), 1);
        chk("out_err_after_hs", 32'(bus.out_err), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_residue = '0;
        bus.out_ready  = 1'b0;

        // Reset state
        rst = 1'b1;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_residue", 32'(bus.out_residue), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 84 x 460 -> 377
        send_n(84, 460);
        end_op();
        collect();

        // 300 + 200 wraps on beat 2 -> 39
        send(300);
        send(200);
        send_n(82, 0);
        end_op();
        collect();

        // Result held under backpressure; offered inputs not consumed.
        send_n(84, 7);
        end_op();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_residue = RES_W'(50);
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 1);
            chk("hold_out_residue", 32'(bus.out_residue), 127);
            chk("hold_in_ready", 32'(bus.in_ready), 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        collect();
        send_n(84, 1);
        end_op();
        collect();

        // Clear mid-operand, with a beat offered alongside it.
        send_n(40, 100);
        clear = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_residue = RES_W'(100);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        model_acc = 0;
        model_err = 1'b0;
        @(negedge clk);
        chk("clear_acc", 32'(bus.out_residue), 0);
        chk("clear_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        send_n(84, 1);
        end_op();
        collect();

        // Asynchronous reset mid-cycle, mid-operand.
        send_n(20, 5);
        bus.in_valid = 1'b0;
        chk("pre_rst_partial", 32'(bus.out_residue), 100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_residue", 32'(bus.out_residue), 0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 1);
        chk("async_rst_out_valid", 32'(bus.out_valid), 0);
        chk("async_rst_out_err", 32'(bus.out_err), 0);
        model_acc = 0;
        model_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_n(84, 2);
        end_op();
        collect();

        // Out-of-range first beat: 500 -> 39, err only with range check.
        send(500);
        send_n(83, 0);
        end_op();
        collect();
        send_n(84, 0);
        end_op();
        collect();

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
